// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush, and an optional
// 2-entry skid buffer that keeps the upstream ready path fully registered.
module pipe_stage_skid #(
    parameter int DATA_W = 106,
    parameter int CTRL_W = 9,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              acc;
    logic              ret;
    logic              load_main;
    logic              load_skid;
    logic              pop_skid;

    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign ret       = out_valid & out_ready;
    assign out_data  = main_data;
    // Bubbles must never leak write/jump enables into the next stage.
    assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
    assign count     = state;

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && ret) begin
                        load_main = 1'b1;
                    end else if (acc) begin
                        if (SKID != 0) begin
                            state_nxt = TWO;
                            load_skid = 1'b1;
                        end else begin
                            load_main = 1'b1;
                        end
                    end else if (ret) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (ret) begin
                        state_nxt = ONE;
                        pop_skid  = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (pop_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Ready depends only on the next occupancy, so out_ready never reaches in_ready combinationally.
            logic ready_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ready_q <= 1'b0;
                end else begin
                    ready_q <= (state_nxt != TWO);
                end
            end
            assign in_ready = ready_q;
        end else begin : g_noskid
            assign in_ready = rst & (~out_valid | out_ready);
        end
    endgenerate

endmodule
